// File: rtl/sram_like_resp_if.sv
// rtl/sram_like_resp_if.sv - data-SRAM-like request/response bundle between initiator and responder
interface sram_like_resp_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        stall;
  logic [2:0]  outstanding;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata, stall,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata, outstanding
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata, stall,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata, outstanding
  );
endinterface

// File: rtl/sram_like_resp.sv
// rtl/sram_like_resp.sv - in-order fixed-latency responder with word-addressed storage array
module sram_like_resp #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            resetn,
  sram_like_resp_if.slave bus
);
  localparam int         PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);
  localparam logic [3:0] DEPTH    = 4'(QDEPTH);

  logic [31:0]       r_mem  [2**ADDR_W];
  logic [31:0]       r_data [QDEPTH];
  logic [2:0]        r_cnt  [QDEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [3:0]        r_count;

  logic              w_addr_ok;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_idx;
  logic              w_unused;

  assign w_idx    = bus.data_sram_addr[ADDR_W+1:2];
  assign w_unused = ^{bus.data_sram_size, bus.data_sram_addr[31:ADDR_W+2],
                      bus.data_sram_addr[1:0]};

  // Acceptance depends only on registered occupancy and stall, so a full
  // queue stays closed even while its head is retiring.
  assign w_addr_ok = resetn & ~bus.stall & (r_count < DEPTH);
  assign w_push    = bus.data_sram_req & w_addr_ok;
  assign w_pop     = (r_count != 4'd0) && (r_cnt[r_head] == 3'd0);

  assign bus.data_sram_addr_ok = w_addr_ok;
  assign bus.data_sram_data_ok = w_pop;
  assign bus.data_sram_rdata   = w_pop ? r_data[r_head] : 32'd0;
  assign bus.outstanding       = (r_count > 4'd7) ? 3'd7 : r_count[2:0];

  always_ff @(posedge clk) begin
    if (w_push && bus.data_sram_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.data_sram_wstrb[k]) begin
          r_mem[w_idx][8*k +: 8] <= bus.data_sram_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 4'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_data[i] <= 32'd0;
        r_cnt[i]  <= 3'd0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (w_push && (r_tail == PTR_W'(i))) begin
          r_cnt[i] <= CNT_INIT;
        end else if (r_cnt[i] != 3'd0) begin
          r_cnt[i] <= r_cnt[i] - 3'd1;
        end
      end
      // The load samples the array before this edge's write lands; a store
      // and a load can never be accepted on the same edge anyway.
      if (w_push) begin
        r_data[r_tail] <= bus.data_sram_wr ? 32'd0 : r_mem[w_idx];
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_like_resp.sv
// tb/tb_sram_like_resp.sv - scoreboard bench over three latency configurations of sram_like_resp
module tb_sram_like_resp;
  localparam int LATS [3] = '{2, 7, 1};

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr, stall;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  sel;
  int          cyc = 0;

  logic [2:0]  v_addr_ok, v_data_ok;
  logic [31:0] v_rdata [3];
  logic [2:0]  v_outst [3];
  logic        addr_ok_m, data_ok_m;
  logic [31:0] rdata_m;
  logic [2:0]  outst_m;

  exp_t        sb[$];
  logic [31:0] ref_mem [3][1024];
  int          vectors = 0;
  int          miscompares = 0;

  logic        s_addr_ok, s_data_ok, s_accept, s_empty;
  logic [31:0] s_rdata, s_exp;
  logic [2:0]  s_outst;
  int          s_cyc, s_due;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_like_resp_if bus ();
    assign bus.data_sram_req   = req & (sel == 2'(g));
    assign bus.data_sram_wr    = wr;
    assign bus.data_sram_size  = size;
    assign bus.data_sram_addr  = addr;
    assign bus.data_sram_wstrb = wstrb;
    assign bus.data_sram_wdata = wdata;
    assign bus.stall           = stall;
    assign v_addr_ok[g]        = bus.data_sram_addr_ok;
    assign v_data_ok[g]        = bus.data_sram_data_ok;
    assign v_rdata[g]          = bus.data_sram_rdata;
    assign v_outst[g]          = bus.outstanding;
    sram_like_resp #(.ADDR_W(10), .LAT(LATS[g]), .QDEPTH(4)) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
    );
  end

  assign addr_ok_m = v_addr_ok[sel];
  assign data_ok_m = v_data_ok[sel];
  assign rdata_m   = v_rdata[sel];
  assign outst_m   = v_outst[sel];

  task automatic put(input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    req = r; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
  endtask

  // Sample one cycle at the falling edge, update the scoreboard, return after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    s_cyc = cyc; s_addr_ok = addr_ok_m; s_data_ok = data_ok_m;
    s_rdata = rdata_m; s_outst = outst_m;
    s_accept = req & addr_ok_m;
    s_empty = 1'b0;
    if (s_data_ok) begin
      if (sb.size() == 0) s_empty = 1'b1;
      else begin
        e = sb.pop_front();
        s_exp = e.data;
        s_due = e.due;
      end
    end
    if (s_accept) begin
      if (wr) begin
        for (int k = 0; k < 4; k++)
          if (wstrb[k]) ref_mem[sel][addr[11:2]][8*k +: 8] = wdata[8*k +: 8];
        e.data = 32'd0;
      end else begin
        e.data = ref_mem[sel][addr[11:2]];
      end
      e.due = cyc + LATS[sel];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      vectors += 4;
      if (v_addr_ok[g] !== 1'b0) begin miscompares++; $display("FAIL reset_addr_ok[%0d]: got %b want 0", g, v_addr_ok[g]); end
      if (v_data_ok[g] !== 1'b0) begin miscompares++; $display("FAIL reset_data_ok[%0d]: got %b want 0", g, v_data_ok[g]); end
      if (v_rdata[g] !== 32'd0) begin miscompares++; $display("FAIL reset_rdata[%0d]: got %h want 0", g, v_rdata[g]); end
      if (v_outst[g] !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding[%0d]: got %0d want 0", g, v_outst[g]); end
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    put(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      vectors += 2;
      if (v_addr_ok[g] !== 1'b1) begin miscompares++; $display("FAIL post_reset_addr_ok[%0d]: got %b want 1", g, v_addr_ok[g]); end
      if (v_data_ok[g] !== 1'b0) begin miscompares++; $display("FAIL post_reset_data_ok[%0d]: got %b want 0", g, v_data_ok[g]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    logic [31:0] got[$];
    logic [31:0] want [7] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h11BB33DD, 32'h0, 32'hCAFEF00D};
    logic        op_wr [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] op_a [7] = '{32'h40, 32'h40, 32'h80, 32'h80, 32'h80, 32'h1000, 32'h0};
    logic [3:0]  op_s [7] = '{4'hF, 4'h0, 4'hF, 4'h5, 4'h0, 4'hF, 4'h0};
    logic [31:0] op_d [7] = '{32'hDEADBEEF, 32'h0, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'hCAFEF00D, 32'h0};
    int acc0 = -1;
    int resp0 = -1;
    sel = 2'd0;
    for (int i = 0; i < 11; i++) begin
      if (i < 7) put(1'b1, op_wr[i], op_a[i], op_s[i], op_d[i]);
      else put(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      step();
      if (i < 7) begin
        vectors++;
        if (s_addr_ok !== 1'b1) begin miscompares++; $display("FAIL store_load_addr_ok op%0d: got %b want 1", i, s_addr_ok); end
      end
      if (i == 0 && s_accept) acc0 = s_cyc;
      if (s_data_ok) begin
        vectors++;
        if (s_empty || s_rdata !== s_exp || s_cyc != s_due) begin
          miscompares++;
          $display("FAIL store_load_resp: rdata %h cycle %0d, want %h cycle %0d (unexpected=%0b)", s_rdata, s_cyc, s_exp, s_due, s_empty);
        end
        if (resp0 < 0) resp0 = s_cyc;
        got.push_back(s_rdata);
      end
    end
    vectors++;
    if (acc0 < 0 || resp0 - acc0 != 2) begin miscompares++; $display("FAIL store_latency: got %0d cycles want 2", resp0 - acc0); end
    vectors++;
    if (got.size() != 7) begin miscompares++; $display("FAIL store_load_count: got %0d want 7", got.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (got[i] !== want[i]) begin miscompares++; $display("FAIL store_load_data%0d: got %h want %h", i, got[i], want[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int  peak = 0;
    int  first = -1;
    logic exp_ok;
    sel = 2'd1;
    for (int rel = 0; rel < 21; rel++) begin
      if (rel <= 8) put(1'b1, 1'b1, 32'(rel * 4), 4'hF, 32'(rel + 1));
      else put(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      step();
      if (rel <= 8) begin
        exp_ok = (rel < 4) || (rel == 8);
        vectors++;
        if (s_addr_ok !== exp_ok) begin miscompares++; $display("FAIL full_addr_ok rel%0d: got %b want %b", rel, s_addr_ok, exp_ok); end
      end
      if (int'(s_outst) > peak) peak = int'(s_outst);
      if (s_data_ok) begin
        if (first < 0) first = rel;
        vectors++;
        if (s_empty || s_rdata !== s_exp || s_cyc != s_due) begin
          miscompares++;
          $display("FAIL full_resp: rdata %h cycle %0d, want %h cycle %0d (unexpected=%0b)", s_rdata, s_cyc, s_exp, s_due, s_empty);
        end
      end
    end
    vectors += 3;
    if (peak != 4) begin miscompares++; $display("FAIL full_peak_outstanding: got %0d want 4", peak); end
    if (first != 7) begin miscompares++; $display("FAIL full_first_data_ok: got rel %0d want 7", first); end
    if (sb.size() != 0) begin miscompares++; $display("FAIL full_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_lat1();
    int lc[$];
    int i = 0;
    sel = 2'd2;
    for (int n = 0; n < 9; n++) begin
      if (n < 8) put(1'b1, 1'b1, 32'h100 + 32'(n * 4), 4'hF, $urandom | 32'h1);
      else put(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      step();
      if (s_data_ok) begin
        vectors++;
        if (s_empty || s_rdata !== s_exp || s_cyc != s_due) begin
          miscompares++;
          $display("FAIL lat1_store_resp: rdata %h cycle %0d, want %h cycle %0d (unexpected=%0b)", s_rdata, s_cyc, s_exp, s_due, s_empty);
        end
      end
    end
    for (int n = 0; n < 9; n++) begin
      if (n < 8) put(1'b1, 1'b0, 32'h100 + 32'(n * 4), 4'h0, 32'd0);
      else put(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      step();
      if (n < 8) begin
        vectors++;
        if (s_addr_ok !== 1'b1) begin miscompares++; $display("FAIL lat1_addr_ok n%0d: got %b want 1", n, s_addr_ok); end
      end
      if (s_data_ok) begin
        vectors++;
        if (s_empty || s_rdata !== s_exp || s_cyc != s_due) begin
          miscompares++;
          $display("FAIL lat1_load_resp: rdata %h cycle %0d, want %h cycle %0d (unexpected=%0b)", s_rdata, s_cyc, s_exp, s_due, s_empty);
        end
        if (s_rdata != 32'd0) lc.push_back(s_cyc);
      end
    end
    vectors++;
    if (lc.size() != 8 || lc[lc.size()-1] - lc[0] != 7) begin
      miscompares++; $display("FAIL lat1_streak: got %0d responses, want 8 consecutive", lc.size());
    end
    lc.delete();
    for (int k = 0; k < 13; k++) begin
      stall = (k == 4) || (k == 5);
      if (i < 8) put(1'b1, 1'b0, 32'h100 + 32'(i * 4), 4'h0, 32'd0);
      else put(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      step();
      if (stall) begin
        vectors++;
        if (s_addr_ok !== 1'b0) begin miscompares++; $display("FAIL lat1_stall_addr_ok k%0d: got %b want 0", k, s_addr_ok); end
      end
      if (s_accept) i++;
      if (s_data_ok) begin
        vectors++;
        if (s_empty || s_rdata !== s_exp || s_cyc != s_due) begin
          miscompares++;
          $display("FAIL lat1_stall_resp: rdata %h cycle %0d, want %h cycle %0d (unexpected=%0b)", s_rdata, s_cyc, s_exp, s_due, s_empty);
        end
        lc.push_back(s_cyc);
      end
    end
    stall = 1'b0;
    vectors++;
    if (lc.size() != 8 || lc[lc.size()-1] - lc[0] != 9) begin
      miscompares++; $display("FAIL lat1_stall_gap: got %0d responses, want 8 spanning 9 cycles", lc.size());
    end
  endtask

  task automatic test_reset_mid();
    int late = 0;
    logic [31:0] got = 32'd0;
    sel = 2'd1;
    put(1'b1, 1'b1, 32'h200, 4'hF, 32'h5A5AA5A5);
    for (int n = 0; n < 9; n++) begin
      step();
      put(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      if (s_data_ok) begin
        vectors++;
        if (s_empty || s_rdata !== s_exp || s_cyc != s_due) begin
          miscompares++;
          $display("FAIL rst_store_resp: rdata %h cycle %0d, want %h cycle %0d (unexpected=%0b)", s_rdata, s_cyc, s_exp, s_due, s_empty);
        end
      end
    end
    for (int n = 0; n < 7; n++) begin
      if (n < 3) put(1'b1, 1'b0, 32'h200, 4'h0, 32'd0);
      else put(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      step();
      if (s_data_ok) begin
        vectors++; miscompares++;
        $display("FAIL rst_early_resp: got data_ok at cycle %0d want none before latency", s_cyc);
      end
    end
    vectors++;
    if (data_ok_m !== 1'b1) begin miscompares++; $display("FAIL rst_pre_data_ok: got %b want 1", data_ok_m); end
    #1 resetn = 1'b0;
    #1;
    vectors += 3;
    if (data_ok_m !== 1'b0) begin miscompares++; $display("FAIL rst_mid_data_ok: got %b want 0", data_ok_m); end
    if (outst_m !== 3'd0) begin miscompares++; $display("FAIL rst_mid_outstanding: got %0d want 0", outst_m); end
    if (addr_ok_m !== 1'b0) begin miscompares++; $display("FAIL rst_mid_addr_ok: got %b want 0", addr_ok_m); end
    sb.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      if (s_data_ok) late++;
    end
    vectors++;
    if (late != 0) begin miscompares++; $display("FAIL rst_ghost_resp: got %0d responses want 0", late); end
    put(1'b1, 1'b0, 32'h200, 4'h0, 32'd0);
    for (int n = 0; n < 9; n++) begin
      step();
      put(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      if (s_data_ok) begin
        vectors++;
        if (s_empty || s_rdata !== s_exp || s_cyc != s_due) begin
          miscompares++;
          $display("FAIL rst_reload_resp: rdata %h cycle %0d, want %h cycle %0d (unexpected=%0b)", s_rdata, s_cyc, s_exp, s_due, s_empty);
        end
        got = s_rdata;
      end
    end
    vectors++;
    if (got !== 32'h5A5AA5A5) begin miscompares++; $display("FAIL rst_array_kept: got %h want 5a5aa5a5", got); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    stall  = 1'b0;
    sel    = 2'd0;
    put(1'b1, 1'b0, 32'd0, 4'd0, 32'd0);
    test_reset();
    test_store_load();
    test_backpressure();
    test_lat1();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
